// File: rtl/game_ctrl_pkg.sv
// Shared types and helpers for the game controller: state encoding,
// field widths and the saturating score adder.
package game_ctrl_pkg;

    localparam int SCORE_W = 9;
    localparam int LIVES_W = 2;
    localparam int CNT_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_MISS  = 3'd4,
        ST_WIN   = 3'd5,
        ST_OVER  = 3'd6,
        ST_BAD   = 3'd7
    } state_e;

    // Score sum that clamps at 511 instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat511(input logic [SCORE_W-1:0] a,
                                                  input logic [SCORE_W-1:0] b);
        logic [SCORE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/game_ctrl_btn_edge.sv
// One-bit rising-edge detector; the pulse is registered, so it appears
// the cycle after the button is first seen high and lasts one cycle.
module btn_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    logic btn_q;
    logic pulse_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            btn_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            btn_q   <= i_btn;
            pulse_q <= i_btn & ~btn_q;
        end
    end

    assign o_pulse = pulse_q;

endmodule

// File: rtl/game_ctrl.sv
// Game sequencing FSM for the breakout game: serve hold, play, pause,
// ball loss bookkeeping, block tracking, game score and high score.
module game_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int LIVES        = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int NBLK         = 22
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_ani_stb,
    input  logic                 i_start,
    input  logic                 i_pause,
    input  logic                 i_endgame,
    input  logic                 i_win_game,
    input  logic [NBLK-1:0]      i_col_detected,
    input  logic [SCORE_W-1:0]   i_score,
    output logic                 o_mode,
    output logic                 o_animate,
    output logic [2:0]           o_state,
    output logic [LIVES_W-1:0]   o_lives,
    output logic [NBLK-1:0]      o_blocks_alive,
    output logic [SCORE_W-1:0]   o_total,
    output logic [SCORE_W-1:0]   o_hi_score
);

    state_e               state_q,  state_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic [LIVES_W-1:0]   lives_q,  lives_d;
    logic [NBLK-1:0]      blocks_q, blocks_d;
    logic [SCORE_W-1:0]   bank_q,   bank_d;
    logic [SCORE_W-1:0]   total_q,  total_d;
    logic [SCORE_W-1:0]   hi_q,     hi_d;

    logic                 start_ev;
    logic                 pause_ev;
    logic                 in_mode;
    logic [NBLK-1:0]      remaining;
    logic [SCORE_W-1:0]   sum;
    logic [CNT_W-1:0]     cnt_inc;

    btn_edge u_start_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_start),
        .o_pulse (start_ev)
    );

    btn_edge u_pause_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_pause),
        .o_pulse (pause_ev)
    );

    assign in_mode   = (state_q == ST_SERVE) || (state_q == ST_PLAY) || (state_q == ST_PAUSE);
    assign remaining = blocks_q & ~i_col_detected;
    assign sum       = sat511(bank_q, i_score);
    assign cnt_inc   = cnt_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lives_d  = lives_q;
        blocks_d = blocks_q;
        bank_d   = bank_q;
        total_d  = total_q;
        hi_d     = hi_q;

        if (in_mode) begin
            blocks_d = remaining;
            total_d  = sum;
        end

        case (state_q)
            ST_IDLE, ST_WIN, ST_OVER: begin
                if (start_ev) begin
                    state_d  = ST_SERVE;
                    lives_d  = LIVES_W'(LIVES);
                    blocks_d = {NBLK{1'b1}};
                    bank_d   = '0;
                    cnt_d    = '0;
                end
            end
            ST_SERVE: begin
                if (i_ani_stb) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(SERVE_FRAMES))
                        state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (i_win_game || (remaining == '0))
                    state_d = ST_WIN;
                else if (i_endgame)
                    state_d = ST_MISS;
                else if (pause_ev)
                    state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (pause_ev)
                    state_d = ST_PLAY;
            end
            ST_MISS: begin
                // Mode is low here, so i_score is still the finished ball's score.
                bank_d = sum;
                if (lives_q != '0)
                    lives_d = lives_q - LIVES_W'(1);
                if (lives_q <= LIVES_W'(1)) begin
                    state_d = ST_OVER;
                end else begin
                    state_d = ST_SERVE;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // total_d is exactly what o_total shows on the first WIN/OVER cycle.
        if (((state_d == ST_WIN) || (state_d == ST_OVER)) && (state_d != state_q)) begin
            if (total_d > hi_q)
                hi_d = total_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            lives_q  <= '0;
            blocks_q <= '0;
            bank_q   <= '0;
            total_q  <= '0;
            hi_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lives_q  <= lives_d;
            blocks_q <= blocks_d;
            bank_q   <= bank_d;
            total_q  <= total_d;
            hi_q     <= hi_d;
        end
    end

    assign o_mode         = in_mode;
    assign o_animate      = (state_q == ST_PLAY);
    assign o_state        = state_q;
    assign o_lives        = lives_q;
    assign o_blocks_alive = blocks_q;
    assign o_total        = total_q;
    assign o_hi_score     = hi_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Randomised scoreboard bench for game_ctrl: a game-rules model predicts
// every post-edge output, a monitor compares one cycle at a time.
module tb_game_ctrl;

    localparam int LIVES        = 3;
    localparam int SERVE_FRAMES = 4;
    localparam int NBLK         = 22;

    typedef struct packed {
        logic [2:0]      state;
        logic            mode;
        logic            animate;
        logic [1:0]      lives;
        logic [NBLK-1:0] blocks;
        logic [8:0]      total;
        logic [8:0]      hi;
    } out_t;

    logic            i_clk = 1'b0;
    logic            i_rst_n = 1'b0;
    logic            i_ani_stb = 1'b0;
    logic            i_start = 1'b0;
    logic            i_pause = 1'b0;
    logic            i_endgame = 1'b0;
    logic            i_win_game = 1'b0;
    logic [NBLK-1:0] i_col_detected = '0;
    logic [8:0]      i_score = '0;
    logic            o_mode;
    logic            o_animate;
    logic [2:0]      o_state;
    logic [1:0]      o_lives;
    logic [NBLK-1:0] o_blocks_alive;
    logic [8:0]      o_total;
    logic [8:0]      o_hi_score;

    game_ctrl #(.LIVES(LIVES), .SERVE_FRAMES(SERVE_FRAMES), .NBLK(NBLK)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_ani_stb      (i_ani_stb),
        .i_start        (i_start),
        .i_pause        (i_pause),
        .i_endgame      (i_endgame),
        .i_win_game     (i_win_game),
        .i_col_detected (i_col_detected),
        .i_score        (i_score),
        .o_mode         (o_mode),
        .o_animate      (o_animate),
        .o_state        (o_state),
        .o_lives        (o_lives),
        .o_blocks_alive (o_blocks_alive),
        .o_total        (o_total),
        .o_hi_score     (o_hi_score)
    );

    always #5 i_clk = ~i_clk;

    int   nChecks = 0;
    int   nFails  = 0;
    out_t expQ[$];

    // Game-rules model: 0 idle, 1 serve, 2 play, 3 pause, 4 miss, 5 win, 6 over.
    int              mState, mLives, mBank, mTotal, mHi, mFrames;
    logic [NBLK-1:0] mBlocks;
    bit              prevStart, prevPause, evStart, evPause;

    function automatic out_t modelOut();
        out_t o;
        o.state   = 3'(mState);
        o.mode    = (mState >= 1 && mState <= 3);
        o.animate = (mState == 2);
        o.lives   = 2'(mLives);
        o.blocks  = mBlocks;
        o.total   = 9'(mTotal);
        o.hi      = 9'(mHi);
        return o;
    endfunction

    task automatic modelReset();
        mState = 0; mLives = 0; mBank = 0; mTotal = 0; mHi = 0; mFrames = 0;
        mBlocks = '0;
        prevStart = 0; prevPause = 0; evStart = 0; evPause = 0;
    endtask

    task automatic modelStep(input bit start, input bit pause, input bit endg, input bit win,
                             input logic [NBLK-1:0] col, input int score, input bit stb);
        int              ballTotal;
        logic [NBLK-1:0] left;
        bit              playing;
        int              nxt;
        ballTotal = (mBank + score > 511) ? 511 : mBank + score;
        left      = mBlocks & ~col;
        playing   = (mState >= 1 && mState <= 3);
        nxt       = mState;
        if (mState == 0 || mState == 5 || mState == 6) begin
            if (evStart) begin
                nxt = 1; mLives = LIVES; mBlocks = '1; mBank = 0; mFrames = 0;
            end
        end else if (mState == 1) begin
            if (stb) mFrames++;
            if (stb && mFrames == SERVE_FRAMES) nxt = 2;
        end else if (mState == 2) begin
            if (win || left == 0) nxt = 5;
            else if (endg) nxt = 4;
            else if (evPause) nxt = 3;
        end else if (mState == 3) begin
            if (evPause) nxt = 2;
        end else if (mState == 4) begin
            mBank = ballTotal;
            nxt = (mLives <= 1) ? 6 : 1;
            mFrames = 0;
            if (mLives > 0) mLives--;
        end else begin
            nxt = 0;
        end
        if (playing) begin
            mBlocks = left;
            mTotal  = ballTotal;
        end
        if ((nxt == 5 || nxt == 6) && nxt != mState && mTotal > mHi) mHi = mTotal;
        mState  = nxt;
        evStart = start && !prevStart;
        evPause = pause && !prevPause;
        prevStart = start;
        prevPause = pause;
    endtask

    task automatic checkOutput(input string name, input out_t exp);
        out_t act;
        act = '{o_state, o_mode, o_animate, o_lives, o_blocks_alive, o_total, o_hi_score};
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s t=%0t: got state=%0d mode=%0b anim=%0b lives=%0d blocks=%h total=%0d hi=%0d, expected state=%0d mode=%0b anim=%0b lives=%0d blocks=%h total=%0d hi=%0d",
                     name, $time, act.state, act.mode, act.animate, act.lives, act.blocks, act.total, act.hi,
                     exp.state, exp.mode, exp.animate, exp.lives, exp.blocks, exp.total, exp.hi);
        end
    endtask

    // Drives one cycle of inputs at the falling edge and queues the prediction for the next rising edge.
    task automatic applyStimulus(input bit rst, input bit start, input bit pause, input bit endg,
                                 input bit win, input logic [NBLK-1:0] col, input int score, input bit stb);
        @(negedge i_clk);
        i_start = start; i_pause = pause; i_endgame = endg; i_win_game = win;
        i_col_detected = col; i_score = 9'(score); i_ani_stb = stb;
        if (rst) begin
            modelReset();
            if (i_rst_n) begin
                i_rst_n = 1'b0;
                #1;
                checkOutput("async_reset", modelOut());
            end
        end else begin
            i_rst_n = 1'b1;
            modelStep(start, pause, endg, win, col, score, stb);
        end
        expQ.push_back(modelOut());
    endtask

    initial begin
        out_t exp;
        forever begin
            @(posedge i_clk);
            #1;
            if (expQ.size() > 0) begin
                exp = expQ.pop_front();
                checkOutput("cycle", exp);
            end
        end
    end

    initial begin
        bit              startLvl, pauseLvl, endg, win, stb;
        logic [NBLK-1:0] col;
        int              score, r;
        modelReset();
        startLvl = 0; pauseLvl = 0;

        repeat (2) applyStimulus(1, 0, 0, 0, 0, '0, 0, 0);
        repeat (2) applyStimulus(0, 0, 0, 0, 0, '0, 0, 0);
        repeat (5) applyStimulus(0, 1, 0, 0, 0, '0, 0, 0);
        repeat (2) applyStimulus(0, 0, 0, 0, 0, '0, 0, 0);
        repeat (4) applyStimulus(0, 0, 0, 0, 0, '0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 22'h000021, 3, 0);
        applyStimulus(0, 0, 1, 0, 0, '0, 3, 0);
        repeat (3) applyStimulus(0, 0, 0, 1, 1, '0, 3, 0);
        applyStimulus(0, 0, 1, 0, 0, '0, 3, 0);
        repeat (2) applyStimulus(0, 0, 0, 0, 0, '0, 15, 0);
        applyStimulus(0, 0, 0, 1, 0, '0, 15, 0);
        repeat (3) applyStimulus(0, 0, 0, 0, 0, '0, 0, 0);

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 699) == 0) begin
                repeat (2) applyStimulus(1, startLvl, pauseLvl, 0, 0, '0, 0, 0);
            end
            startLvl = startLvl ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
            if (pauseLvl)
                pauseLvl = ($urandom_range(0, 1) != 0);
            else
                pauseLvl = (mState == 2 || mState == 3) ? ($urandom_range(0, 19) == 0)
                                                       : ($urandom_range(0, 49) == 0);
            endg = (mState == 2 || mState == 3) ? ($urandom_range(0, 29) == 0)
                                                : ($urandom_range(0, 9) == 0);
            win  = ($urandom_range(0, 149) == 0);
            r    = $urandom_range(0, 99);
            if (r < 10)       col = NBLK'(1) << $urandom_range(0, NBLK - 1);
            else if (r == 99) col = '1;
            else              col = '0;
            score = ($urandom_range(0, 19) == 0) ? $urandom_range(400, 511) : $urandom_range(0, 40);
            stb   = $urandom_range(0, 1) != 0;
            applyStimulus(0, startLvl, pauseLvl, endg, win, col, score, stb);
        end

        for (int k = 0; k < 10 && expQ.size() > 0; k++) @(posedge i_clk);
        #2;
        if (expQ.size() > 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
